reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin write arbiter that shares one n-bit enabled register (clk/reset/eable/D/Q storage element) between four requesters. It selects one pending requester, drives the register's enable and data inputs for one or more cycles, and returns a one-hot grant that doubles as the write acknowledge. It sits directly in front of the shared register. The register's Q output fans out to all requesters unchanged.

## Interface
- n, 4, data width of the shared register and of every requester data bus
- MAX_LOCK, 8, maximum consecutive writes one locked owner may perform before forced release (1..255)

- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- req  input  4  per-requester write request, bit i = requester i
- lock  input  4  per-requester burst-hold request, meaningful only while that requester is granted
- d0, d1, d2, d3  input  n each  write data of requester 0..3
- reg_en  output  1  drives the shared register's eable input
- reg_d  output  n  drives the shared register's D input
- gnt  output  4  one-hot grant/acknowledge, high in every cycle a write of that requester is presented
- busy  output  1  high whenever state is WRITE

## Operation
- Two states: IDLE, WRITE. All outputs are registered.
- Round-robin pointer ptr (2 bits): the requester after the last served one has highest priority. Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE with req == 0: stay in IDLE. reg_en=0, gnt=0.
- IDLE with req != 0: pick the first set bit in search order as idx. Next state is WRITE. Next-cycle outputs: reg_en=1, reg_d=d[idx] (sampled this cycle), gnt=1<<idx, busy=1. Set ptr=idx+1 and burst count cnt=1.
- WRITE, continuing:
  - Continue only if lock[idx]=1, req[idx]=1 and cnt<MAX_LOCK.
  - While continuing, remain in WRITE with the same idx and gnt. Sample a fresh d[idx] into reg_d, keep reg_en=1, and increment cnt.
- WRITE, releasing:
  - Release on any other condition: next state IDLE with reg_en=0, gnt=0, busy=0.
  - No arbitration happens in the release cycle. There is one mandatory IDLE cycle between owners.
- A requester still holding req after release competes again. Because ptr has advanced, other pending requesters are served first.
- Requesters hold req and data stable until they see gnt. Each cycle with gnt[i]=1 is exactly one write of d[i] (value sampled one cycle earlier).
- reg_d holds its last value when reg_en=0.
- reset: state=IDLE, ptr=0, cnt=0, reg_en=0, reg_d=0, gnt=0, busy=0. Reset mid-WRITE aborts the burst immediately; no write is presented in the cycle after reset.

## Timing
- Req-to-write latency: req sampled at edge k; reg_en/gnt high in cycle k..k+1; register Q updates at edge k+1.
- Single-write throughput: one write every 2 cycles (WRITE, IDLE).
- Locked burst: up to MAX_LOCK back-to-back writes, one per cycle, then a forced IDLE cycle.
- Simultaneous requests: exactly one grant. At most one gnt bit is ever set.
- lock without a matching granted req is ignored.
- A req deasserting during WRITE ends the burst after the current write.

## Configuration
- REG_ARB_LOCK_EN:
  - Defined: lock input and MAX_LOCK counter are implemented as above.
  - Undefined: lock is ignored and no cnt logic exists. Every grant is a single-cycle WRITE followed by IDLE, i.e. always release after one write.

## Test plan
- Reset: hold reset 2 cycles with req=4'b1111 -> reg_en=0, gnt=0, reg_d=0, busy=0 throughout; first grant after reset goes to requester 0.
- Single request: req=4'b0100, d2=12 -> one cycle later gnt=4'b0100, reg_en=1, reg_d=12; register Q=12 on the following edge; then one IDLE cycle.
- Round-robin fairness: req=4'b1111 held with d0..d3=1,2,4,8 -> gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001; Q steps 1,2,4,8.
- Locked burst (REG_ARB_LOCK_EN): req[1]=lock[1]=1, d1 changing 3,5,9,13,... each cycle, MAX_LOCK=8 -> 8 consecutive cycles gnt=4'b0010 with reg_d following d1 one cycle late, then forced IDLE; with req[3] also high, requester 3 is granted next.
- Burst end on req drop: lock[1]=1, req[1] drops after 3 grants -> exactly 3 write cycles, then IDLE; without REG_ARB_LOCK_EN the same stimulus gives alternating 1-write/1-IDLE.
- Reset mid-burst: assert reset during the 3rd locked write -> the next cycle has reg_en=0 and gnt=0, ptr=0, and Q keeps the last written value.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//
// Round-robin write arbiter that places four requesters in front of one shared
// n-bit enabled register (clk/reset/eable/D/Q). The arbiter drives the
// register's enable and D inputs. It returns a one-hot grant that also serves
// as the write acknowledge: each cycle with gnt[i]=1 presents exactly one write
// of d[i], sampled one cycle earlier. All outputs are registered.
//
// Optional feature macro: REG_ARB_LOCK_EN
//   defined   - a granted requester that holds lock[i] and req[i] keeps
//               ownership for up to MAX_LOCK back-to-back writes.
//   undefined - lock is ignored. Every grant is a single write followed by one
//               IDLE cycle.
//
// Parameters
//   n         data width of the shared register and of each requester bus
//   MAX_LOCK  maximum consecutive writes of one locked owner (1..255)
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high
//   req     in   [3:0]   per-requester write request
//   lock    in   [3:0]   per-requester burst hold (only meaningful when granted)
//   d0..d3  in   [n-1:0] write data of requester 0..3
//   reg_en  out          enable input of the shared register
//   reg_d   out  [n-1:0] D input of the shared register (holds when reg_en=0)
//   gnt     out  [3:0]   one-hot grant / write acknowledge
//   busy    out          high while in WRITE
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int n        = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [3:0]   lock,
  input  logic [n-1:0] d0,
  input  logic [n-1:0] d1,
  input  logic [n-1:0] d2,
  input  logic [n-1:0] d3,
  output logic         reg_en,
  output logic [n-1:0] reg_d,
  output logic [3:0]   gnt,
  output logic         busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t      state_reg;
  logic [1:0]  ptr_reg;    // highest-priority requester for the next arbitration
  logic [1:0]  idx_reg;    // current owner while in WRITE

  // Requester data gathered into an array so it can be indexed by owner.
  logic [n-1:0] d_arr [4];
  assign d_arr[0] = d0;
  assign d_arr[1] = d1;
  assign d_arr[2] = d2;
  assign d_arr[3] = d3;

  // Requests rotated so that req_rot[0] is the requester at ptr_reg. A
  // fixed-priority pick on the rotated vector then yields the round-robin
  // winner as an offset from ptr_reg.
  logic [3:0] req_rot;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign req_rot[gi] = req[ptr_reg + 2'(gi)];
    end
  endgenerate

  logic       pick_valid;
  logic [1:0] pick_off;
  logic [1:0] pick_idx;

  always_comb begin
    pick_valid = 1'b0;
    pick_off   = 2'd0;
    // Scan from the lowest priority to the highest so that the first set bit
    // in search order is the last one assigned.
    for (int k = 3; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_valid = 1'b1;
        pick_off   = 2'(k);
      end
    end
  end

  assign pick_idx = ptr_reg + pick_off;

  // Burst continuation decision for the current owner.
  logic cont;

`ifdef REG_ARB_LOCK_EN
  logic [7:0] cnt_reg;    // writes already presented in the current burst

  assign cont = lock[idx_reg] & req[idx_reg] & (cnt_reg < 8'(MAX_LOCK));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= 8'd0;
    end else if (state_reg == IDLE) begin
      if (pick_valid) begin
        cnt_reg <= 8'd1;
      end
    end else if (cont) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end
`else
  // Without burst support every grant lasts exactly one write.
  logic unused_lock;
  localparam int unused_max_lock = MAX_LOCK;
  assign unused_lock = ^lock;
  assign cont        = 1'b0;
`endif

  // Main FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      idx_reg   <= 2'd0;
      reg_en    <= 1'b0;
      reg_d     <= '0;
      gnt       <= 4'b0000;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg <= WRITE;
            idx_reg   <= pick_idx;
            ptr_reg   <= pick_idx + 2'd1;
            reg_en    <= 1'b1;
            reg_d     <= d_arr[pick_idx];
            gnt       <= 4'b0001 << pick_idx;
            busy      <= 1'b1;
          end else begin
            reg_en    <= 1'b0;
            gnt       <= 4'b0000;
            busy      <= 1'b0;
          end
        end

        WRITE: begin
          if (cont) begin
            // Same owner and grant; a fresh data word each cycle.
            reg_d     <= d_arr[idx_reg];
          end else begin
            // Release without arbitrating: this forces one IDLE cycle between
            // owners. reg_d keeps its last value.
            state_reg <= IDLE;
            reg_en    <= 1'b0;
            gnt       <= 4'b0000;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          reg_en    <= 1'b0;
          gnt       <= 4'b0000;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Directed bench for reg_write_arbiter. Stimulus pushes the expected writes
// (grant, data) into a scoreboard queue. A negedge monitor pops and compares
// every presented write, and checks the shared-register Q one cycle later.
// The cycle-exact idle/grant patterns are checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [3:0]   lock;
  logic [N-1:0] d0, d1, d2, d3;
  logic         reg_en;
  logic [N-1:0] reg_d;
  logic [3:0]   gnt;
  logic         busy;

  always #5 clk = ~clk;

  reg_write_arbiter #(.n(N), .MAX_LOCK(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .lock   (lock),
    .d0     (d0),
    .d1     (d1),
    .d2     (d2),
    .d3     (d3),
    .reg_en (reg_en),
    .reg_d  (reg_d),
    .gnt    (gnt),
    .busy   (busy)
  );

  // The shared enabled register the arbiter sits in front of.
  logic [N-1:0] q = '0;
  always @(posedge clk) if (reg_en === 1'b1) q <= reg_d;

  typedef struct {
    logic [3:0]   g;
    logic [N-1:0] d;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  logic [N-1:0] q_exp;
  bit           q_pend = 1'b0;

`ifdef REG_ARB_LOCK_EN
  localparam int DROP_CYCLES = 3;
`else
  localparam int DROP_CYCLES = 5;
`endif

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    exp_t e;
    if (q_pend) begin
      tests++;
      if (q !== q_exp) begin
        fails++;
        $display("[TB] FAIL q_update: got %0d want %0d", q, q_exp);
      end
      q_pend = 1'b0;
    end
    tests++;
    if (busy !== reg_en) begin
      fails++;
      $display("[TB] FAIL busy_track: busy=%b reg_en=%b", busy, reg_en);
    end
    if (reg_en === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write: gnt=%b reg_d=%0d", gnt, reg_d);
      end else begin
        e = sb.pop_front();
        if (gnt !== e.g || reg_d !== e.d) begin
          fails++;
          $display("[TB] FAIL write: got gnt=%b d=%0d want gnt=%b d=%0d",
                   gnt, reg_d, e.g, e.d);
        end else begin
          $display("[TB] write gnt=%b d=%0d ok", gnt, reg_d);
        end
        q_exp  = e.d;
        q_pend = 1'b1;
      end
    end else begin
      tests++;
      if (gnt !== 4'b0000) begin
        fails++;
        $display("[TB] FAIL gnt_idle: got gnt=%b want 0000", gnt);
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    end else begin
      $display("[TB] %s = %0d ok", name, got);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [N-1:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    sb.push_back(e);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [3:0]   gseq [10];
    logic [N-1:0] vals [8];
    int cnt;
    int cyc;

    // Reset held two cycles with all requests pending.
    reset = 1'b1;
    req   = 4'b1111;
    lock  = 4'b0000;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd4; d3 = 4'd8;
    for (int k = 0; k < 2; k++) begin
      tick;
      check("rst_reg_en", 32'(reg_en), 0);
      check("rst_gnt",    32'(gnt),    0);
      check("rst_reg_d",  32'(reg_d),  0);
      check("rst_busy",   32'(busy),   0);
    end

    // Round-robin fairness, first grant after reset to requester 0.
    gseq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
             4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    push(4'b0001, 4'd1);
    push(4'b0010, 4'd2);
    push(4'b0100, 4'd4);
    push(4'b1000, 4'd8);
    push(4'b0001, 4'd1);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(gseq[k]));
      if (k == 8) req = 4'b0000;
    end
    check("rr_q", 32'(q), 1);

    // Single request from requester 2.
    d2  = 4'd12;
    req = 4'b0100;
    push(4'b0100, 4'd12);
    tick;
    check("single_gnt",   32'(gnt),   32'(4'b0100));
    check("single_reg_d", 32'(reg_d), 12);
    req = 4'b0000;
    tick;
    check("single_idle", 32'(gnt), 0);
    tick;
    check("single_q", 32'(q), 12);

    // Locked burst ended by req[1] dropping after three grants.
    vals = '{4'd3, 4'd5, 4'd9, 4'd13, 4'd2, 4'd6, 4'd10, 4'd14};
    d1   = vals[0];
    req  = 4'b0010;
    lock = 4'b0010;
    for (int k = 0; k < 3; k++) push(4'b0010, vals[k]);
    cnt = 0;
    cyc = 0;
    while (cnt < 3 && cyc < 20) begin
      tick;
      cyc++;
      if (gnt[1]) begin
        cnt++;
        if (cnt == 3) begin
          req  = 4'b0000;
          lock = 4'b0000;
        end else begin
          d1 = vals[cnt];
        end
      end
    end
    check("drop_grants", 32'(cnt), 3);
    check("drop_cycles", 32'(cyc), 32'(DROP_CYCLES));
    tick;
    check("drop_release", 32'(gnt), 0);
    tick;
    check("drop_stay_idle", 32'(reg_en), 0);

`ifdef REG_ARB_LOCK_EN
    // Burst capped at MAX_LOCK, then requester 3 takes over.
    d1   = vals[0];
    d3   = 4'd7;
    req  = 4'b0010;
    lock = 4'b0010;
    for (int k = 0; k < 8; k++) push(4'b0010, vals[k]);
    push(4'b1000, 4'd7);
    cnt = 0;
    cyc = 0;
    while (cnt < 8 && cyc < 30) begin
      tick;
      cyc++;
      if (gnt[1]) begin
        cnt++;
        req = 4'b1010;
        if (cnt < 8) d1 = vals[cnt];
      end
    end
    check("lock_grants", 32'(cnt), 8);
    check("lock_cycles", 32'(cyc), 8);
    tick;
    check("lock_forced_idle", 32'(gnt), 0);
    tick;
    check("lock_next_owner", 32'(gnt), 32'(4'b1000));
    req  = 4'b0000;
    lock = 4'b0000;
    tick;
    check("lock_after_idle", 32'(gnt), 0);
`endif

    // Reset asserted during the third write of requester 1.
    d1   = vals[0];
    req  = 4'b0010;
    lock = 4'b0010;
    for (int k = 0; k < 3; k++) push(4'b0010, vals[k]);
    cnt = 0;
    cyc = 0;
    while (cnt < 3 && cyc < 20) begin
      tick;
      cyc++;
      if (gnt[1]) begin
        cnt++;
        if (cnt == 3) reset = 1'b1;
        else          d1 = vals[cnt];
      end
    end
    check("mid_grants", 32'(cnt), 3);
    tick;
    check("mid_reg_en", 32'(reg_en), 0);
    check("mid_gnt",    32'(gnt),    0);
    check("mid_busy",   32'(busy),   0);
    check("mid_reg_d",  32'(reg_d),  0);
    check("mid_q",      32'(q),      9);

    // ptr must be back at 0: with 1 and 3 pending, requester 1 wins.
    reset = 1'b0;
    lock  = 4'b0000;
    req   = 4'b1010;
    d1    = 4'd4;
    d3    = 4'd11;
    push(4'b0010, 4'd4);
    tick;
    check("post_rst_ptr", 32'(gnt), 32'(4'b0010));
    req = 4'b0000;
    tick;
    tick;
    check("post_rst_q", 32'(q), 4);

    repeat (3) tick;
    check("sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
